// File: rtl/io_input_debounce.sv
// rtl/io_input_debounce.sv - synchronise, debounce and pack board switches and push-buttons
// Keys are inverted after synchronisation; everything downstream is active-high.
module io_input_debounce #(
    parameter int N_SW            = 10,
    parameter int N_KEY           = 4,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N_SW-1:0]   i_sw,
    input  logic [N_KEY-1:0]  i_key_n,
    input  logic [N_KEY-1:0]  i_evt_clr,
    output logic [N_SW-1:0]   o_sw,
    output logic [N_KEY-1:0]  o_key,
    output logic [N_KEY-1:0]  o_key_press,
    output logic [N_KEY-1:0]  o_key_evt,
    output logic [31:0]       o_io_sw
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int N_IN  = N_SW + N_KEY;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_SW-1:0]  r_sw_s1, r_sw_s2;
    logic [N_KEY-1:0] r_key_s1, r_key_s2;
    logic [N_IN-1:0]  w_sync;
    logic [N_IN-1:0]  r_stable;
    logic [CNT_W-1:0] r_cnt [N_IN];
    logic [N_KEY-1:0] w_key;
    logic [N_KEY-1:0] w_press_nxt;
    logic [N_KEY-1:0] r_key_q;
    logic [N_KEY-1:0] r_press;
    logic [N_KEY-1:0] r_evt;
    logic [31:0]      w_pack;
    logic [31:0]      r_io_sw;

    // Keys reset to the released raw level so no phantom press follows reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_key_s1 <= '1;
            r_key_s2 <= '1;
        end else begin
            r_sw_s1  <= i_sw;
            r_sw_s2  <= r_sw_s1;
            r_key_s1 <= i_key_n;
            r_key_s2 <= r_key_s1;
        end
    end

    assign w_sync = {~r_key_s2, r_sw_s2};

    // Any cycle agreeing with the stable value restarts that bit's count.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_stable <= '0;
            for (int i = 0; i < N_IN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (w_sync[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_stable[i] <= w_sync[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_key       = r_stable[N_IN-1:N_SW];
    assign w_press_nxt = w_key & ~r_key_q;

    always_comb begin
        w_pack = '0;
        w_pack[N_SW-1:0]                   = r_stable[N_SW-1:0];
        w_pack[N_SW+N_KEY-1:N_SW]          = w_key;
        w_pack[N_SW+2*N_KEY-1:N_SW+N_KEY]  = r_evt;
    end

    // A press on the same edge as a clear keeps the flag set.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_key_q <= '0;
            r_press <= '0;
            r_evt   <= '0;
            r_io_sw <= '0;
        end else begin
            r_key_q <= w_key;
            r_press <= w_press_nxt;
            r_evt   <= w_press_nxt | (r_evt & ~i_evt_clr);
            r_io_sw <= w_pack;
        end
    end

    assign o_sw        = r_stable[N_SW-1:0];
    assign o_key       = w_key;
    assign o_key_press = r_press;
    assign o_key_evt   = r_evt;
    assign o_io_sw     = r_io_sw;

endmodule

// File: tb/tb_io_input_debounce.sv
// tb/tb_io_input_debounce.sv - randomized bench for io_input_debounce against a windowed reference model
module tb_io_input_debounce;

    localparam int N_SW  = 10;
    localparam int N_KEY = 4;
    localparam int D     = 4;
    localparam int N     = N_SW + N_KEY;

    logic             i_clk;
    logic             i_reset;
    logic [N_SW-1:0]  i_sw;
    logic [N_KEY-1:0] i_key_n;
    logic [N_KEY-1:0] i_evt_clr;
    logic [N_SW-1:0]  o_sw;
    logic [N_KEY-1:0] o_key;
    logic [N_KEY-1:0] o_key_press;
    logic [N_KEY-1:0] o_key_evt;
    logic [31:0]      o_io_sw;

    io_input_debounce #(
        .N_SW(N_SW), .N_KEY(N_KEY), .DEBOUNCE_CYCLES(D)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_sw(i_sw), .i_key_n(i_key_n),
        .i_evt_clr(i_evt_clr), .o_sw(o_sw), .o_key(o_key),
        .o_key_press(o_key_press), .o_key_evt(o_key_evt), .o_io_sw(o_io_sw)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: a bit flips once its last D synced samples all disagree with it.
    logic [N-1:0]     hist [$];
    logic [N-1:0]     m_stab, m_stab_d1;
    logic [N_KEY-1:0] m_press, m_evt;
    logic [31:0]      m_io;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < D + 2; k++) hist.push_back('0);
        m_stab = '0; m_stab_d1 = '0; m_press = '0; m_evt = '0; m_io = '0;
    endtask

    task automatic model_edge();
        logic [N-1:0]     nstab;
        logic [N_KEY-1:0] npress;
        logic             flip;
        hist.push_front({~i_key_n, i_sw});
        void'(hist.pop_back());
        nstab = m_stab;
        for (int b = 0; b < N; b++) begin
            flip = 1'b1;
            for (int k = 2; k <= D + 1; k++)
                if (hist[k][b] == m_stab[b]) flip = 1'b0;
            if (flip) nstab[b] = ~m_stab[b];
        end
        npress = m_stab[N-1:N_SW] & ~m_stab_d1[N-1:N_SW];
        m_io = {{(32-N-N_KEY){1'b0}}, m_evt, m_stab};
        m_evt = npress | (m_evt & ~i_evt_clr);
        m_press = npress;
        m_stab_d1 = m_stab;
        m_stab = nstab;
    endtask

    task automatic compare_all();
        check("sw",    32'(o_sw),        32'(m_stab[N_SW-1:0]));
        check("key",   32'(o_key),       32'(m_stab[N-1:N_SW]));
        check("press", 32'(o_key_press), 32'(m_press));
        check("evt",   32'(o_key_evt),   32'(m_evt));
        check("io_sw", o_io_sw,          m_io);
    endtask

    task automatic step();
        @(posedge i_clk);
        if (i_reset) model_edge();
        @(negedge i_clk);
        compare_all();
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        model_reset();
        #1;
        check("rst_sw",    32'(o_sw),        32'h0);
        check("rst_key",   32'(o_key),       32'h0);
        check("rst_press", 32'(o_key_press), 32'h0);
        check("rst_evt",   32'(o_key_evt),   32'h0);
        check("rst_io",    o_io_sw,          32'h0);
        step();
        step();
        i_reset = 1'b1;
    endtask

    initial begin
        int hold;
        int clr_mode;
        i_reset   = 1'b0;
        i_sw      = 10'h3FF;
        i_key_n   = 4'h0;
        i_evt_clr = 4'h0;
        model_reset();
        @(negedge i_clk);
        do_reset();

        for (int e = 1; e <= 5; e++) step();
        check("lat_sw_e5", 32'(o_sw), 32'h0);
        step();
        check("lat_sw_e6", 32'(o_sw), 32'h3FF);
        step();
        check("lat_io_e7", o_io_sw, 32'h0000_3FFF);

        i_sw = 10'h3FE;
        for (int c = 0; c < 3; c++) step();
        i_sw = 10'h3FF;
        for (int c = 0; c < 8; c++) begin
            step();
            check("glitch_sw0", 32'(o_sw), 32'h3FF);
        end

        i_sw = '0;
        i_key_n = '1;
        for (int seg = 0; seg < 300; seg++) begin
            if ($urandom_range(0, 30) == 0) do_reset();
            if ($urandom_range(0, 1) == 0) i_sw = i_sw ^ N_SW'($urandom & $urandom);
            if ($urandom_range(0, 1) == 0) i_key_n = i_key_n ^ N_KEY'($urandom & $urandom);
            hold = $urandom_range(1, 9);
            clr_mode = $urandom_range(0, 3);
            for (int c = 0; c < hold; c++) begin
                if (clr_mode == 0)
                    i_evt_clr = '1;
                else if ($urandom_range(0, 3) == 0)
                    i_evt_clr = N_KEY'($urandom);
                else
                    i_evt_clr = '0;
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/io_input_debounce.md
Name: io_input_debounce

Overview:
- Board-input conditioning stage that sits directly upstream of the pipelined core's `i_io_sw` port.
- Synchronises and debounces the raw DE10-Standard slide switches and active-low push-buttons.
- Converts the buttons to active-high, generates one-cycle press pulses and sticky press flags that software can clear.
- Packs everything into the 32-bit switch word read by the core.

Parameters:
- N_SW, 10, number of slide switches
- N_KEY, 4, number of push-buttons
- DEBOUNCE_CYCLES, 100000, cycles an input must stay stable before acceptance (10 ms at 10 MHz); legal range ≥ 2
- CNT_W, $clog2(DEBOUNCE_CYCLES), debounce counter width (derived, not overridden)
- Constraint: N_SW + 2*N_KEY ≤ 32

Ports:
- i_clk  input  1  core clock (divided board clock)
- i_reset  input  1  asynchronous, active-low reset
- i_sw  input  N_SW  raw slide switches; ON=1; asynchronous to i_clk
- i_key_n  input  N_KEY  raw push-buttons; pressed=0; asynchronous to i_clk
- i_evt_clr  input  N_KEY  per-key clear of sticky press flags; active-high, level-sampled
- o_sw  output  N_SW  debounced switch state
- o_key  output  N_KEY  debounced key state; active-high, pressed=1
- o_key_press  output  N_KEY  one-cycle pulse on each debounced press (0→1 of o_key)
- o_key_evt  output  N_KEY  sticky press flags
- o_io_sw  output  32  packed word, feeds core `i_io_sw`

Behaviour:
- **Reset.** Reset asynchronous, active-low; asserting i_reset mid-debounce aborts all counts immediately. Reset values:
  - Switch synchronisers and o_sw: 0.
  - Key synchronisers: 1 (released, raw level).
  - o_key, o_key_press, o_key_evt: 0.
  - All counters: 0.
  - o_io_sw: 0.
- **Synchroniser.** Every input bit passes a 2-FF synchroniser. Keys are inverted after synchronisation; all downstream logic is active-high.
- **Debounce, per bit, one independent counter each.**
  - sync ≠ stable: counter increments.
  - sync == stable: counter clears to 0 (glitch rejection).
  - Counter == DEBOUNCE_CYCLES-1 and sync ≠ stable: stable ← sync and counter ← 0 on that edge.
  - Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.
- **Latency.** A raw change held steady appears on o_sw/o_key on rising edge DEBOUNCE_CYCLES+2, counting the first edge that samples the new raw level as edge 1.
- **Glitch rejection.** A raw pulse shorter than DEBOUNCE_CYCLES cycles after synchronisation produces no output change.
- **Press pulse.** o_key_press[i] is registered: high for exactly the cycle after o_key[i] rises, i.e. o_key_press[i] = o_key[i] & ~o_key_q[i]. No pulse on release.
- **Sticky flags.**
  - o_key_evt[i] sets on a press pulse.
  - It clears on a cycle where i_evt_clr[i]=1 and no press pulse is present.
  - Simultaneous pulse and clear: set wins (flag stays 1).
  - Flags hold indefinitely otherwise.
- **Packing.** o_io_sw is registered, one cycle after its sources:
  - [N_SW-1:0] = o_sw
  - [N_SW+N_KEY-1:N_SW] = o_key
  - [N_SW+2*N_KEY-1:N_SW+N_KEY] = o_key_evt
  - remaining upper bits = 0
  - With defaults: [9:0] SW, [13:10] KEY, [17:14] events, [31:18] 0.
- **Independence.** All bits are debounced independently; simultaneous changes on several bits settle independently, each with its own latency.
- **Clocking.** No combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
1. **Reset values.** Hold i_reset=0 with i_sw=10'h3FF, i_key_n=4'h0 → o_sw=0, o_key=0, o_key_evt=0, o_io_sw=32'h0. Release reset and hold inputs → o_sw=10'h3FF on edge 6 after release, o_io_sw=32'h00003FFF one edge later.
2. **Glitch rejection.** i_sw[0] 0→1 for 3 cycles then back to 0 → o_sw[0] stays 0 throughout. Hold 1 for 8 cycles → o_sw[0]=1 exactly 6 edges after the first sampling edge.
3. **Press.** Press KEY[1] (i_key_n[1]=0) for 10 cycles → o_key[1]=1 after 6 edges; o_key_press[1] high exactly one cycle; o_key_evt[1]=1 and o_io_sw[15]=1. Release → o_key[1]=0, no second pulse, o_key_evt[1] stays 1.
4. **Set beats clear.** Assert i_evt_clr[1] for 1 cycle → o_key_evt[1]=0. Assert i_evt_clr[1] continuously while a new press pulse occurs → o_key_evt[1]=1 on the pulse cycle, 0 on the following cycle.
5. **Reset mid-operation.** Toggle all SW and press all KEY, then assert i_reset after 2 mismatch cycles → outputs immediately 0 with no pulse. After deassert, the full debounce latency restarts from zero.
6. **Bouncing input.** Bounce i_key_n[3] with a 1,0,1,0,0,0,0,0,0 pattern → exactly one o_key_press[3] pulse, o_key[3]=1 only after 4 consecutive synced-low cycles.
